// File: rtl/clock_text_pixel_gen.sv
`default_nettype none
// ============================================================================
//  Module      : clock_text_pixel_gen
//  Description : Renders an "HH:MM:SS" text field from an 8x16 glyph ROM into
//                a registered 12-bit VGA pixel, with an optional blinking colon.
//  Revision    : 1.0  initial release
// ============================================================================
module clock_text_pixel_gen #(
    parameter logic [9:0]  X0         = 10'd192,
    parameter logic [9:0]  Y0         = 10'd208,
    parameter int          SCALE_LOG2 = 2,
    parameter bit          BLINK      = 1'b1,
    parameter bit          LZ_BLANK   = 1'b1,
    parameter logic [11:0] FG_RGB     = 12'hFFF,
    parameter logic [11:0] BG_RGB     = 12'h000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        video_on,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        sec_tick,
    input  logic [3:0]  hr10,
    input  logic [3:0]  hr1,
    input  logic [3:0]  min10,
    input  logic [3:0]  min1,
    input  logic [3:0]  sec10,
    input  logic [3:0]  sec1,
    output logic [10:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic [11:0] rgb
);

    localparam logic [9:0]  c_field_w    = 10'(64 << SCALE_LOG2);
    localparam logic [9:0]  c_field_h    = 10'(16 << SCALE_LOG2);
    localparam logic [6:0]  c_colon_code = 7'h3a;
    localparam logic [10:0] c_blank_addr = 11'h300;

    logic [9:0] w_rx;
    logic [9:0] w_ry;
    logic       w_in_field;
    logic [2:0] w_idx;
    logic [2:0] w_col;
    logic [3:0] w_row;
    logic [3:0] w_digit;
    logic       w_is_colon;
    logic       w_colon_on;
    logic       w_blank;
    logic [6:0] w_code;

    logic [2:0] r_col_d;
    logic       r_show_d;
    logic       r_vid_d;

    // Offsets only matter when x>=X0 / y>=Y0, so the subtraction never wraps
    // for pixels that end up inside the field.
    assign w_rx       = x - X0;
    assign w_ry       = y - Y0;
    assign w_in_field = (x >= X0) && (w_rx < c_field_w) && (y >= Y0) && (w_ry < c_field_h);
    assign w_idx      = w_rx[SCALE_LOG2+3 +: 3];
    assign w_col      = w_rx[SCALE_LOG2 +: 3];
    assign w_row      = w_ry[SCALE_LOG2 +: 4];

    always_comb begin
        w_digit    = 4'd0;
        w_is_colon = 1'b0;
        case (w_idx)
            3'd0:    w_digit    = hr10;
            3'd1:    w_digit    = hr1;
            3'd2:    w_is_colon = 1'b1;
            3'd3:    w_digit    = min10;
            3'd4:    w_digit    = min1;
            3'd5:    w_is_colon = 1'b1;
            3'd6:    w_digit    = sec10;
            default: w_digit    = sec1;
        endcase
    end

    assign w_blank = !w_in_field
                  || (w_digit > 4'd9)
                  || ((w_idx == 3'd0) && LZ_BLANK && (hr10 == 4'd0))
                  || (w_is_colon && BLINK && !w_colon_on);

    assign w_code   = w_is_colon ? c_colon_code : {3'b011, w_digit};
    // Blank cells still point at a defined ROM entry so rom_data is never X.
    assign rom_addr = w_blank ? c_blank_addr : {w_code, w_row};

    generate
        if (BLINK) begin : g_blink
            logic r_colon_on;
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    r_colon_on <= 1'b1;
                else if (sec_tick)
                    r_colon_on <= ~r_colon_on;
            end
            assign w_colon_on = r_colon_on;
        end else begin : g_no_blink
            assign w_colon_on = 1'b1;
        end
    endgenerate

    // Stage 1 runs alongside the ROM's internal address register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col_d  <= 3'd0;
            r_show_d <= 1'b0;
            r_vid_d  <= 1'b0;
        end else begin
            r_col_d  <= w_col;
            r_show_d <= w_in_field & ~w_blank;
            r_vid_d  <= video_on;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rgb <= 12'h000;
        else if (!r_vid_d)
            rgb <= 12'h000;
        else if (r_show_d && rom_data[3'd7 - r_col_d])
            rgb <= FG_RGB;
        else
            rgb <= BG_RGB;
    end

endmodule
`default_nettype wire

// File: tb/tb_clock_text_pixel_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clock_text_pixel_gen
//  Description : Directed bench for clock_text_pixel_gen with a registered ROM
//                model and an expected-pixel queue matched to the 2-clk latency.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_clock_text_pixel_gen;

    localparam logic [9:0]  c_x0 = 10'd192;
    localparam logic [9:0]  c_y0 = 10'd208;
    localparam logic [11:0] c_fg = 12'hFF0;
    localparam logic [11:0] c_bg = 12'h123;

    logic        clk = 1'b0;
    logic        reset;
    logic        video_on;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        sec_tick;
    logic [3:0]  hr10, hr1, min10, min1, sec10, sec1;
    logic [10:0] rom_addr_s2, rom_addr_s0;
    logic [7:0]  rom_data_s2, rom_data_s0;
    logic [11:0] rgb_s2, rgb_s0;

    typedef struct {
        logic [11:0] v;
        bit          chk;
        bit          inst;
        string       tag;
    } exp_t;
    exp_t exp_q[$];

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    clock_text_pixel_gen #(.X0(c_x0), .Y0(c_y0), .SCALE_LOG2(2), .BLINK(1'b1), .LZ_BLANK(1'b1),
                           .FG_RGB(c_fg), .BG_RGB(c_bg)) dut (
        .clk(clk), .reset(reset), .video_on(video_on), .x(x), .y(y), .sec_tick(sec_tick),
        .hr10(hr10), .hr1(hr1), .min10(min10), .min1(min1), .sec10(sec10), .sec1(sec1),
        .rom_addr(rom_addr_s2), .rom_data(rom_data_s2), .rgb(rgb_s2));

    clock_text_pixel_gen #(.X0(c_x0), .Y0(c_y0), .SCALE_LOG2(0), .BLINK(1'b1), .LZ_BLANK(1'b1),
                           .FG_RGB(c_fg), .BG_RGB(c_bg)) dut_s0 (
        .clk(clk), .reset(reset), .video_on(video_on), .x(x), .y(y), .sec_tick(sec_tick),
        .hr10(hr10), .hr1(hr1), .min10(min10), .min1(min1), .sec10(sec10), .sec1(sec1),
        .rom_addr(rom_addr_s0), .rom_data(rom_data_s0), .rgb(rgb_s0));

    // Simplified font: digits are solid 7-wide bars on rows 2..13, colon dots
    // at columns 3-4 of rows 4,5,10,11; everything else (incl. 11'h300) is 0.
    function automatic logic [7:0] rom_fn(input logic [10:0] a);
        logic [6:0] code;
        logic [3:0] row;
        code = a[10:4];
        row  = a[3:0];
        if (code >= 7'h30 && code <= 7'h39)
            return (row >= 4'd2 && row <= 4'd13) ? 8'hFE : 8'h00;
        if (code == 7'h3a)
            return (row == 4'd4 || row == 4'd5 || row == 4'd10 || row == 4'd11) ? 8'h18 : 8'h00;
        return 8'h00;
    endfunction

    always @(posedge clk) begin
        rom_data_s2 <= rom_fn(rom_addr_s2);
        rom_data_s0 <= rom_fn(rom_addr_s0);
    end

    task automatic check(input logic [11:0] obs, input logic [11:0] expv, input string tag);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock of streaming: queue the pixel expected for the current inputs,
    // advance, and retire the entry whose 2-clk latency has elapsed.
    task automatic cyc(input bit chk, input bit inst, input logic [11:0] v, input string tag);
        exp_t e;
        e.v = v; e.chk = chk; e.inst = inst; e.tag = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 2) begin
            e = exp_q.pop_front();
            if (e.chk)
                check(e.inst ? rgb_s0 : rgb_s2, e.v, e.tag);
        end
    endtask

    task automatic probe(input logic [11:0] v, input string tag);
        cyc(1'b1, 1'b0, v, tag);
        cyc(1'b0, 1'b0, 12'h000, "");
    endtask

    task automatic tick();
        sec_tick = 1'b1;
        cyc(1'b0, 1'b0, 12'h000, "");
        sec_tick = 1'b0;
    endtask

    initial begin
        reset = 1'b1; video_on = 1'b1; sec_tick = 1'b0;
        hr10 = 4'd1; hr1 = 4'd2; min10 = 4'd3; min1 = 4'd4; sec10 = 4'd5; sec1 = 4'd6;
        x = c_x0; y = c_y0 + 10'd8;

        repeat (2) @(posedge clk);
        #1;
        check(rgb_s2, 12'h000, "rst_hold");
        reset = 1'b0;
        @(posedge clk); #1;
        check(rgb_s2, 12'h000, "rst_rel_clk1");
        @(posedge clk); #1;
        check(rgb_s2, c_fg, "rst_rel_clk2");

        #3 reset = 1'b1;
        #1 check(rgb_s2, 12'h000, "rst_async");
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();

        x = c_x0 + 10'd40;
        #1 check({1'b0, rom_addr_s2}, 12'h322, "addr_digit");
        probe(c_fg, "digit_render");

        x = c_x0 - 10'd1;
        probe(c_bg, "edge_left");
        x = c_x0 + 10'd256;
        probe(c_bg, "edge_right");
        x = c_x0 + 10'd40; y = c_y0 + 10'd64;
        probe(c_bg, "edge_bottom");
        y = c_y0 + 10'd8; video_on = 1'b0;
        probe(12'h000, "video_off");
        video_on = 1'b1;

        hr10 = 4'd0; x = c_x0 + 10'd8;
        probe(c_bg, "lz_blank");
        hr10 = 4'd1;
        probe(c_fg, "lz_shown");

        sec1 = 4'hB; x = c_x0 + 10'd232;
        #1 check({1'b0, rom_addr_s2}, 12'h300, "addr_invalid");
        probe(c_bg, "invalid_digit");
        sec1 = 4'd6;
        probe(c_fg, "valid_sec1");

        x = c_x0 + 10'd76; y = c_y0 + 10'd16;
        #1 check({1'b0, rom_addr_s2}, 12'h3a4, "addr_colon");
        probe(c_fg, "colon_on");
        tick();
        probe(c_bg, "colon_off");
        tick();
        probe(c_fg, "colon_on_again");

        sec_tick = 1'b1;
        cyc(1'b1, 1'b0, c_fg, "colon_tick_same");
        sec_tick = 1'b0;
        cyc(1'b1, 1'b0, c_bg, "colon_tick_next");
        cyc(1'b0, 1'b0, 12'h000, "");
        tick();

        sec1 = 4'd8; y = c_y0 + 10'd2;
        for (int i = 0; i < 8; i++) begin
            x = c_x0 + 10'd56 + 10'(i);
            cyc(1'b1, 1'b1, (i < 7) ? c_fg : c_bg, $sformatf("sweep_col%0d", i));
        end
        cyc(1'b0, 1'b1, 12'h000, "");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
